// File: rtl/anabellek_hakemi_if.sv
// ---------------------------------------------------------------------------
// anabellek_hakemi_if
//
// Purpose:
//   Groups every request/response signal around the main-memory arbiter into
//   one bundle: the instruction-cache (getir) port, the data-cache (bellek)
//   port, the arbiter-free flag and the main-memory (anabellek) port.
//   The signal names keep their _i/_o suffixes as seen from the arbiter, so a
//   name reads the same inside the arbiter and in the surrounding system.
//
// Parameters:
//   ADRES_BIT  address width of every address signal
//   OBEK_BIT   cache block width of every data signal
//
// Modports:
//   slave   the arbiter's view (requests and memory responses come in)
//   master  the surrounding system: both caches plus the main memory
//
// Signal summary (direction as seen by the arbiter):
//   getir_istek_i / getir_adres_i                  fetch-side block read request
//   getir_veri_hazir_o / getir_obek_o              fetch-side done pulse + block
//   bellek_istek_i / bellek_adres_i / bellek_yaz_i data-side request, address, op
//   bellek_yazilacak_obek_i                        data-side block to write
//   bellek_veri_hazir_o / bellek_obek_o            data-side done pulse + block
//   hakem_musait_o                                 arbiter idle
//   anabellek_istek_o / _yaz_o / _oku_o            memory request strobes
//   anabellek_adres_o / _yazilacak_obek_o          memory address and write block
//   anabellek_musait_i / _veri_hazir_i / _obek_i   memory accept, done, read block
// ---------------------------------------------------------------------------
interface anabellek_hakemi_if #(
    parameter int ADRES_BIT = 32,
    parameter int OBEK_BIT  = 128
);

    // Fetch (instruction cache) side
    logic                 getir_istek_i;
    logic [ADRES_BIT-1:0] getir_adres_i;
    logic                 getir_veri_hazir_o;
    logic [OBEK_BIT-1:0]  getir_obek_o;

    // Data cache side
    logic                 bellek_istek_i;
    logic [ADRES_BIT-1:0] bellek_adres_i;
    logic                 bellek_yaz_i;
    logic [OBEK_BIT-1:0]  bellek_yazilacak_obek_i;
    logic                 bellek_veri_hazir_o;
    logic [OBEK_BIT-1:0]  bellek_obek_o;

    // Arbiter status
    logic                 hakem_musait_o;

    // Main memory side
    logic                 anabellek_istek_o;
    logic                 anabellek_yaz_o;
    logic                 anabellek_oku_o;
    logic [ADRES_BIT-1:0] anabellek_adres_o;
    logic [OBEK_BIT-1:0]  anabellek_yazilacak_obek_o;
    logic                 anabellek_musait_i;
    logic                 anabellek_veri_hazir_i;
    logic [OBEK_BIT-1:0]  anabellek_obek_i;

    // The arbiter itself
    modport slave (
        input  getir_istek_i,
        input  getir_adres_i,
        output getir_veri_hazir_o,
        output getir_obek_o,
        input  bellek_istek_i,
        input  bellek_adres_i,
        input  bellek_yaz_i,
        input  bellek_yazilacak_obek_i,
        output bellek_veri_hazir_o,
        output bellek_obek_o,
        output hakem_musait_o,
        output anabellek_istek_o,
        output anabellek_yaz_o,
        output anabellek_oku_o,
        output anabellek_adres_o,
        output anabellek_yazilacak_obek_o,
        input  anabellek_musait_i,
        input  anabellek_veri_hazir_i,
        input  anabellek_obek_i
    );

    // Everything around the arbiter: both caches and the main memory
    modport master (
        output getir_istek_i,
        output getir_adres_i,
        input  getir_veri_hazir_o,
        input  getir_obek_o,
        output bellek_istek_i,
        output bellek_adres_i,
        output bellek_yaz_i,
        output bellek_yazilacak_obek_i,
        input  bellek_veri_hazir_o,
        input  bellek_obek_o,
        input  hakem_musait_o,
        input  anabellek_istek_o,
        input  anabellek_yaz_o,
        input  anabellek_oku_o,
        input  anabellek_adres_o,
        input  anabellek_yazilacak_obek_o,
        output anabellek_musait_i,
        output anabellek_veri_hazir_i,
        output anabellek_obek_i
    );

endinterface

// File: rtl/anabellek_hakemi.sv
// ---------------------------------------------------------------------------
// anabellek_hakemi
//
// Purpose:
//   Main-memory arbiter shared by the instruction cache (getir) and the data
//   cache (bellek). One block transaction is in flight at a time. When both
//   caches ask at once, the side that was not served last wins, so neither
//   can starve the other. Every output comes straight from a flop.
//
//   Transaction flow:
//     BOSTA  idle; requests sampled, the winner and its address/op/block latched
//     ISTEK  request strobes held on the memory port until the memory accepts
//     BEKLE  waiting for memory completion; read data captured for the winner
//     TAMAM  one-cycle done pulse to the winner, fairness pointer updated
//
// Parameters:
//   ADRES_BIT  address width
//   OBEK_BIT   cache block width
//
// Ports:
//   clk_i     clock, all state changes on the rising edge
//   rst_i     asynchronous active-high reset
//   hakem_if  request/response bundle (slave modport), see anabellek_hakemi_if
// ---------------------------------------------------------------------------
module anabellek_hakemi #(
    parameter int ADRES_BIT = 32,
    parameter int OBEK_BIT  = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    anabellek_hakemi_if.slave hakem_if
);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTEK = 2'd1,
        BEKLE = 2'd2,
        TAMAM = 2'd3
    } durum_t;

    typedef enum logic {
        GETIR  = 1'b0,
        BELLEK = 1'b1
    } taraf_t;

    // Blocks are 16 bytes, so the memory always sees a block-aligned address.
    localparam logic [ADRES_BIT-1:0] ALT_MASKE = ADRES_BIT'(4'hF);

    // Registered state
    durum_t               r_durum;
    taraf_t               r_son_hizmet;
    taraf_t               r_kazanan;
    logic                 r_yaz;
    logic [ADRES_BIT-1:0] r_adres;
    logic [OBEK_BIT-1:0]  r_yaz_obek;
    logic                 r_istek;
    logic                 r_yaz_strobe;
    logic                 r_oku_strobe;
    logic                 r_getir_hazir;
    logic                 r_bellek_hazir;
    logic [OBEK_BIT-1:0]  r_getir_obek;
    logic [OBEK_BIT-1:0]  r_bellek_obek;
    logic                 r_hakem_musait;

    // Next-state values
    durum_t               w_durum;
    taraf_t               w_son_hizmet;
    taraf_t               w_kazanan;
    logic                 w_yaz;
    logic [ADRES_BIT-1:0] w_adres;
    logic [OBEK_BIT-1:0]  w_yaz_obek;
    logic                 w_istek;
    logic                 w_yaz_strobe;
    logic                 w_oku_strobe;
    logic                 w_getir_hazir;
    logic                 w_bellek_hazir;
    logic [OBEK_BIT-1:0]  w_getir_obek;
    logic [OBEK_BIT-1:0]  w_bellek_obek;
    logic                 w_hakem_musait;

    // Arbitration helpers
    taraf_t               w_secilen;
    logic                 w_secilen_yaz;
    logic [ADRES_BIT-1:0] w_ham_adres;
    logic [ADRES_BIT-1:0] w_hizali_adres;

    // Picks who would win if a transaction started this cycle. A lone
    // requester always wins; on a tie the pointer r_son_hizmet names the side
    // served last, and the other side gets the grant. The pointer resets to
    // getir, so the very first tie goes to the data cache.
    always_comb begin
        w_secilen = GETIR;
        if (hakem_if.getir_istek_i && hakem_if.bellek_istek_i) begin
            if (r_son_hizmet == GETIR) begin
                w_secilen = BELLEK;
            end else begin
                w_secilen = GETIR;
            end
        end else if (hakem_if.bellek_istek_i) begin
            w_secilen = BELLEK;
        end
    end

    // Only the data cache can write; its address is block-aligned before it
    // is latched so later changes on the request inputs cannot leak through.
    assign w_secilen_yaz  = (w_secilen == BELLEK) && hakem_if.bellek_yaz_i;
    assign w_ham_adres    = (w_secilen == BELLEK) ? hakem_if.bellek_adres_i
                                                  : hakem_if.getir_adres_i;
    assign w_hizali_adres = w_ham_adres & ~ALT_MASKE;

    // Next-state and next-output logic. Latched transaction fields and the
    // read-block registers hold by default; strobes and done pulses default
    // low so each state only has to name what it drives high. Memory
    // completion is only looked at in BEKLE, so a stray completion in any
    // other state is ignored.
    always_comb begin
        w_durum        = r_durum;
        w_son_hizmet   = r_son_hizmet;
        w_kazanan      = r_kazanan;
        w_yaz          = r_yaz;
        w_adres        = r_adres;
        w_yaz_obek     = r_yaz_obek;
        w_istek        = 1'b0;
        w_yaz_strobe   = 1'b0;
        w_oku_strobe   = 1'b0;
        w_getir_hazir  = 1'b0;
        w_bellek_hazir = 1'b0;
        w_getir_obek   = r_getir_obek;
        w_bellek_obek  = r_bellek_obek;

        case (r_durum)
            BOSTA: begin
                if (hakem_if.getir_istek_i || hakem_if.bellek_istek_i) begin
                    w_kazanan    = w_secilen;
                    w_yaz        = w_secilen_yaz;
                    w_adres      = w_hizali_adres;
                    w_yaz_obek   = w_secilen_yaz ? hakem_if.bellek_yazilacak_obek_i
                                                 : '0;
                    w_istek      = 1'b1;
                    w_yaz_strobe = w_secilen_yaz;
                    w_oku_strobe = !w_secilen_yaz;
                    w_durum      = ISTEK;
                end
            end

            ISTEK: begin
                if (hakem_if.anabellek_musait_i) begin
                    w_durum = BEKLE;
                end else begin
                    w_istek      = 1'b1;
                    w_yaz_strobe = r_yaz;
                    w_oku_strobe = !r_yaz;
                end
            end

            BEKLE: begin
                if (hakem_if.anabellek_veri_hazir_i) begin
                    if (r_kazanan == GETIR) begin
                        w_getir_hazir = 1'b1;
                        if (!r_yaz) begin
                            w_getir_obek = hakem_if.anabellek_obek_i;
                        end
                    end else begin
                        w_bellek_hazir = 1'b1;
                        if (!r_yaz) begin
                            w_bellek_obek = hakem_if.anabellek_obek_i;
                        end
                    end
                    w_durum = TAMAM;
                end
            end

            TAMAM: begin
                w_son_hizmet = r_kazanan;
                w_durum      = BOSTA;
            end

            default: begin
                w_durum = BOSTA;
            end
        endcase

        w_hakem_musait = (w_durum == BOSTA);
    end

    // State and output registers. Reset drops any transaction in flight: the
    // FSM returns to idle and nothing remembers the abandoned request, so a
    // late memory completion finds the arbiter in BOSTA and is ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_durum        <= BOSTA;
            r_son_hizmet   <= GETIR;
            r_kazanan      <= GETIR;
            r_yaz          <= 1'b0;
            r_adres        <= '0;
            r_yaz_obek     <= '0;
            r_istek        <= 1'b0;
            r_yaz_strobe   <= 1'b0;
            r_oku_strobe   <= 1'b0;
            r_getir_hazir  <= 1'b0;
            r_bellek_hazir <= 1'b0;
            r_getir_obek   <= '0;
            r_bellek_obek  <= '0;
            r_hakem_musait <= 1'b1;
        end else begin
            r_durum        <= w_durum;
            r_son_hizmet   <= w_son_hizmet;
            r_kazanan      <= w_kazanan;
            r_yaz          <= w_yaz;
            r_adres        <= w_adres;
            r_yaz_obek     <= w_yaz_obek;
            r_istek        <= w_istek;
            r_yaz_strobe   <= w_yaz_strobe;
            r_oku_strobe   <= w_oku_strobe;
            r_getir_hazir  <= w_getir_hazir;
            r_bellek_hazir <= w_bellek_hazir;
            r_getir_obek   <= w_getir_obek;
            r_bellek_obek  <= w_bellek_obek;
            r_hakem_musait <= w_hakem_musait;
        end
    end

    // Outputs are straight register copies.
    assign hakem_if.getir_veri_hazir_o         = r_getir_hazir;
    assign hakem_if.getir_obek_o               = r_getir_obek;
    assign hakem_if.bellek_veri_hazir_o        = r_bellek_hazir;
    assign hakem_if.bellek_obek_o              = r_bellek_obek;
    assign hakem_if.hakem_musait_o             = r_hakem_musait;
    assign hakem_if.anabellek_istek_o          = r_istek;
    assign hakem_if.anabellek_yaz_o            = r_yaz_strobe;
    assign hakem_if.anabellek_oku_o            = r_oku_strobe;
    assign hakem_if.anabellek_adres_o          = r_adres;
    assign hakem_if.anabellek_yazilacak_obek_o = r_yaz_obek;

endmodule

// File: tb/tb_anabellek_hakemi.sv
// ---------------------------------------------------------------------------
// tb_anabellek_hakemi
//
// Purpose:
//   Directed bench for the main-memory arbiter. A small main-memory model
//   accepts requests after a programmable number of cycles and answers after
//   another programmable delay; read data is either a fixed block or the
//   accepted address repeated four times, so each side's block is easy to
//   predict by hand.
//
// Ports: none (top-level bench)
// ---------------------------------------------------------------------------
module tb_anabellek_hakemi;

    localparam int ADRES_BIT = 32;
    localparam int OBEK_BIT  = 128;

    logic clk;
    logic rst;

    anabellek_hakemi_if #(.ADRES_BIT(ADRES_BIT), .OBEK_BIT(OBEK_BIT)) hIf ();

    anabellek_hakemi #(.ADRES_BIT(ADRES_BIT), .OBEK_BIT(OBEK_BIT)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .hakem_if (hIf)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for latency measurements.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag,
                               input logic [127:0] observed,
                               input logic [127:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Main-memory model knobs and bookkeeping.
    int           musaitGecikme = 0;
    int           veriGecikme   = 1;
    bit           adresVeri     = 1'b0;
    logic [127:0] okuVeri       = '0;
    int           mmFaz         = 0;
    int           mmSayac       = 0;
    int           kabulSayisi   = 0;
    int           veriCyc       = 0;
    logic [31:0]  sonKabulAdres = '0;
    bit           sonKabulYaz   = 1'b0;
    logic [127:0] sonKabulObek  = '0;
    logic [31:0]  kabulAdresleri[$];

    // Main-memory model: while a request is up it waits musaitGecikme cycles
    // before raising musait for one cycle, then after veriGecikme more cycles
    // raises veri_hazir for one cycle. Writes answer with a junk block that
    // must never show up on a cache port.
    initial begin
        hIf.anabellek_musait_i     = 1'b0;
        hIf.anabellek_veri_hazir_i = 1'b0;
        hIf.anabellek_obek_i       = '0;
        forever begin
            @(negedge clk);
            hIf.anabellek_musait_i     = 1'b0;
            hIf.anabellek_veri_hazir_i = 1'b0;
            if (mmFaz == 0) begin
                if (hIf.anabellek_istek_o) begin
                    if (mmSayac >= musaitGecikme) begin
                        hIf.anabellek_musait_i = 1'b1;
                        kabulSayisi++;
                        sonKabulAdres = hIf.anabellek_adres_o;
                        sonKabulYaz   = hIf.anabellek_yaz_o;
                        sonKabulObek  = hIf.anabellek_yazilacak_obek_o;
                        kabulAdresleri.push_back(hIf.anabellek_adres_o);
                        mmFaz   = 1;
                        mmSayac = 0;
                    end else begin
                        mmSayac++;
                    end
                end
            end else begin
                mmSayac++;
                if (mmSayac >= veriGecikme) begin
                    hIf.anabellek_veri_hazir_i = 1'b1;
                    if (sonKabulYaz)
                        hIf.anabellek_obek_i = {4{32'hDEAD_BEEF}};
                    else if (adresVeri)
                        hIf.anabellek_obek_i = {4{sonKabulAdres}};
                    else
                        hIf.anabellek_obek_i = okuVeri;
                    veriCyc = cyc;
                    mmFaz   = 0;
                    mmSayac = 0;
                end
            end
        end
    end

    int grantSirasi[$];
    int ciftPulse   = 0;
    int sonPulseCyc = 0;

    // Drives both cache request ports; called just after a falling edge.
    task automatic applyStimulus(input bit          getirIstek,
                                 input logic [31:0] getirAdres,
                                 input bit          bellekIstek,
                                 input logic [31:0] bellekAdres,
                                 input bit          bellekYaz,
                                 input logic [127:0] bellekObek);
        hIf.getir_istek_i           = getirIstek;
        hIf.getir_adres_i           = getirAdres;
        hIf.bellek_istek_i          = bellekIstek;
        hIf.bellek_adres_i          = bellekAdres;
        hIf.bellek_yaz_i            = bellekYaz;
        hIf.bellek_yazilacak_obek_i = bellekObek;
    endtask

    // Watches done pulses until 'hedef' of them arrive, logging who was served.
    // With kendiniBirak a side drops its request as soon as it is served;
    // otherwise both keep requesting. All requests drop at the end.
    task automatic serveRequests(input int hedef, input bit kendiniBirak, input int budget);
        int pulses = 0;
        int n      = 0;
        while (pulses < hedef && n < budget) begin
            @(negedge clk);
            n++;
            if (hIf.getir_veri_hazir_o && hIf.bellek_veri_hazir_o) ciftPulse++;
            if (hIf.getir_veri_hazir_o) begin
                grantSirasi.push_back(0);
                pulses++;
                sonPulseCyc = cyc;
                if (kendiniBirak) hIf.getir_istek_i = 1'b0;
            end
            if (hIf.bellek_veri_hazir_o) begin
                grantSirasi.push_back(1);
                pulses++;
                sonPulseCyc = cyc;
                if (kendiniBirak) hIf.bellek_istek_i = 1'b0;
            end
        end
        if (pulses < hedef) checkOutput("serve_timeout_pulses", 128'(pulses), 128'(hedef));
        hIf.getir_istek_i  = 1'b0;
        hIf.bellek_istek_i = 1'b0;
    endtask

    // Whole-run guard in case something stalls outside the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not complete, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence: reset, single fetch read, simultaneous requests,
    // continuous alternation, stalled write, reset during BEKLE.
    initial begin
        int pulseSay;
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        repeat (3) @(negedge clk);

        checkOutput("reset_hakem_musait", 128'(hIf.hakem_musait_o), 128'd1);
        checkOutput("reset_istek", 128'(hIf.anabellek_istek_o), 128'd0);
        checkOutput("reset_veri_hazir", 128'({hIf.getir_veri_hazir_o, hIf.bellek_veri_hazir_o}), 128'd0);
        checkOutput("reset_adres", 128'(hIf.anabellek_adres_o), 128'd0);
        checkOutput("reset_getir_obek", hIf.getir_obek_o, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] fetch-only read");
        musaitGecikme = 0;
        veriGecikme   = 3;
        adresVeri     = 1'b0;
        okuVeri       = {16{8'hAA}};
        applyStimulus(1'b1, 32'h0000_1234, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("getir_istek_latency", 128'(hIf.anabellek_istek_o), 128'd1);
        checkOutput("getir_strobes_yaz_oku", 128'({hIf.anabellek_yaz_o, hIf.anabellek_oku_o}), 128'b01);
        checkOutput("getir_adres_hizali", 128'(hIf.anabellek_adres_o), 128'h0000_1230);
        checkOutput("getir_hakem_mesgul", 128'(hIf.hakem_musait_o), 128'd0);
        serveRequests(1, 1'b1, 50);
        checkOutput("getir_veri_latency", 128'(sonPulseCyc - veriCyc), 128'd1);
        checkOutput("getir_obek", hIf.getir_obek_o, {16{8'hAA}});
        checkOutput("getir_bellek_pulse_yok", 128'(hIf.bellek_veri_hazir_o), 128'd0);
        @(negedge clk);
        checkOutput("getir_tek_pulse", 128'(hIf.getir_veri_hazir_o), 128'd0);
        checkOutput("getir_sonra_musait", 128'(hIf.hakem_musait_o), 128'd1);

        $display("[TB] simultaneous fetch and data reads");
        musaitGecikme = 1;
        veriGecikme   = 2;
        adresVeri     = 1'b1;
        grantSirasi.delete();
        kabulAdresleri.delete();
        applyStimulus(1'b1, 32'h0000_2004, 1'b1, 32'h0000_3008, 1'b0, '0);
        serveRequests(2, 1'b1, 80);
        checkOutput("esit_grant_sayisi", 128'(grantSirasi.size()), 128'd2);
        checkOutput("esit_ilk_bellek", 128'(grantSirasi.size() > 0 ? grantSirasi[0] : 9), 128'd1);
        checkOutput("esit_ikinci_getir", 128'(grantSirasi.size() > 1 ? grantSirasi[1] : 9), 128'd0);
        checkOutput("esit_kabul_sayisi", 128'(kabulAdresleri.size()), 128'd2);
        checkOutput("esit_ilk_adres", 128'(kabulAdresleri.size() > 0 ? kabulAdresleri[0] : 32'hFFFF_FFFF), 128'h0000_3000);
        checkOutput("esit_ikinci_adres", 128'(kabulAdresleri.size() > 1 ? kabulAdresleri[1] : 32'hFFFF_FFFF), 128'h0000_2000);
        checkOutput("esit_bellek_obek", hIf.bellek_obek_o, {4{32'h0000_3000}});
        checkOutput("esit_getir_obek", hIf.getir_obek_o, {4{32'h0000_2000}});
        checkOutput("esit_cift_pulse", 128'(ciftPulse), 128'd0);

        $display("[TB] continuous requests from both sides");
        musaitGecikme = 0;
        veriGecikme   = 1;
        grantSirasi.delete();
        applyStimulus(1'b1, 32'h0000_4444, 1'b1, 32'h0000_5555, 1'b0, '0);
        serveRequests(6, 1'b0, 120);
        checkOutput("surekli_grant_sayisi", 128'(grantSirasi.size()), 128'd6);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("surekli_grant_%0d", k),
                        128'(k < grantSirasi.size() ? grantSirasi[k] : 9),
                        128'((k % 2 == 0) ? 1 : 0));
        end
        checkOutput("surekli_getir_obek", hIf.getir_obek_o, {4{32'h0000_4440}});
        checkOutput("surekli_bellek_obek", hIf.bellek_obek_o, {4{32'h0000_5550}});
        checkOutput("surekli_cift_pulse", 128'(ciftPulse), 128'd0);
        @(negedge clk);

        $display("[TB] stalled data write");
        musaitGecikme = 5;
        veriGecikme   = 1;
        grantSirasi.delete();
        applyStimulus(1'b0, '0, 1'b1, 32'h8000_0010, 1'b1, {16{8'h55}});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("yaz_strobes_%0d", k),
                        128'({hIf.anabellek_istek_o, hIf.anabellek_yaz_o, hIf.anabellek_oku_o}), 128'b110);
            checkOutput($sformatf("yaz_adres_%0d", k), 128'(hIf.anabellek_adres_o), 128'h8000_0010);
            checkOutput($sformatf("yaz_obek_%0d", k), hIf.anabellek_yazilacak_obek_o, {16{8'h55}});
        end
        serveRequests(1, 1'b1, 50);
        checkOutput("yaz_grant_bellek", 128'(grantSirasi.size() > 0 ? grantSirasi[0] : 9), 128'd1);
        checkOutput("yaz_kabul_yaz", 128'(sonKabulYaz), 128'd1);
        checkOutput("yaz_kabul_obek", sonKabulObek, {16{8'h55}});
        checkOutput("yaz_bellek_obek_degismez", hIf.bellek_obek_o, {4{32'h0000_5550}});
        @(negedge clk);

        $display("[TB] reset while waiting for memory");
        musaitGecikme = 0;
        veriGecikme   = 6;
        applyStimulus(1'b1, 32'h0000_6000, 1'b0, '0, 1'b0, '0);
        repeat (3) @(negedge clk);
        checkOutput("bekle_hakem_mesgul", 128'(hIf.hakem_musait_o), 128'd0);
        checkOutput("bekle_istek_dusuk", 128'(hIf.anabellek_istek_o), 128'd0);
        rst = 1'b1;
        hIf.getir_istek_i = 1'b0;
        #1;
        checkOutput("rst_hakem_musait", 128'(hIf.hakem_musait_o), 128'd1);
        checkOutput("rst_getir_obek", hIf.getir_obek_o, 128'd0);
        checkOutput("rst_bellek_obek", hIf.bellek_obek_o, 128'd0);
        checkOutput("rst_adres", 128'(hIf.anabellek_adres_o), 128'd0);
        checkOutput("rst_veri_hazir", 128'({hIf.getir_veri_hazir_o, hIf.bellek_veri_hazir_o}), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        pulseSay = 0;
        repeat (8) begin
            @(negedge clk);
            if (hIf.getir_veri_hazir_o || hIf.bellek_veri_hazir_o) pulseSay++;
        end
        checkOutput("rst_sonrasi_pulse_yok", 128'(pulseSay), 128'd0);
        checkOutput("rst_bellek_cevap_verdi", 128'(mmFaz), 128'd0);
        checkOutput("rst_sonrasi_musait", 128'(hIf.hakem_musait_o), 128'd1);
        checkOutput("rst_sonrasi_istek", 128'(hIf.anabellek_istek_o), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
